// File: rtl/part_4_sub_seq.sv
// Multi-cycle subtractor: diff = a - b, one SLICE_W-bit slice per clock, LSB slice first.
// Implemented as a + ~b + 1 with the carry kept in a register between slices.
module part_4_sub_seq #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SLICE_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] diff,
  output logic              borrow,
  output logic              overflow
);

  localparam int unsigned NS    = DATA_W / SLICE_W;
  localparam int unsigned IDX_W = (NS > 1) ? $clog2(NS) : 1;
  localparam int unsigned MSB   = DATA_W - 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state, state_n;
  logic [DATA_W-1:0]   a_r, a_n;
  logic [DATA_W-1:0]   nb_r, nb_n;
  logic                carry, carry_n;
  logic [IDX_W-1:0]    idx, idx_n;
  logic [DATA_W-1:0]   diff_n;
  logic                busy_n, done_n, borrow_n, overflow_n;
  logic [SLICE_W-1:0]  a_sl, nb_sl;
  logic [SLICE_W:0]    sum;

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      a_r      <= '0;
      nb_r     <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      diff     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      a_r      <= a_n;
      nb_r     <= nb_n;
      carry    <= carry_n;
      idx      <= idx_n;
      diff     <= diff_n;
      busy     <= busy_n;
      done     <= done_n;
      borrow   <= borrow_n;
      overflow <= overflow_n;
    end
  end

  // Select the current operand slices and add them with the running carry.
  always_comb begin
    a_sl  = '0;
    nb_sl = '0;
    for (int i = 0; i < NS; i++) begin
      if (idx == IDX_W'(i)) begin
        a_sl  = a_r[i*SLICE_W +: SLICE_W];
        nb_sl = nb_r[i*SLICE_W +: SLICE_W];
      end
    end
    sum = {1'b0, a_sl} + {1'b0, nb_sl} + {{SLICE_W{1'b0}}, carry};
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state;
    a_n        = a_r;
    nb_n       = nb_r;
    carry_n    = carry;
    idx_n      = idx;
    diff_n     = diff;
    busy_n     = busy;
    done_n     = 1'b0;
    borrow_n   = borrow;
    overflow_n = overflow;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = CALC;
          a_n     = a;
          nb_n    = ~b;
          carry_n = 1'b1;
          idx_n   = '0;
          diff_n  = '0;
          busy_n  = 1'b1;
        end
      end
      CALC: begin
        for (int i = 0; i < NS; i++) begin
          if (idx == IDX_W'(i)) diff_n[i*SLICE_W +: SLICE_W] = sum[SLICE_W-1:0];
        end
        carry_n = sum[SLICE_W];
        idx_n   = idx + IDX_W'(1);
        if (idx == IDX_W'(NS - 1)) begin
          state_n    = DONE;
          idx_n      = '0;
          done_n     = 1'b1;
          borrow_n   = ~sum[SLICE_W];
          overflow_n = (a_r[MSB] != ~nb_r[MSB]) && (diff_n[MSB] != a_r[MSB]);
        end
      end
      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_part_4_sub_seq.sv
// Directed bench for part_4_sub_seq: vector table plus handshake/reset corner sequences.
module tb_part_4_sub_seq;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] a, b;
  logic        busy, done, borrow, overflow;
  logic [31:0] diff;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        br;
    logic        ov;
  } vec_t;

  vec_t vecs[8];

  part_4_sub_seq dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Issue one operation and check latency, result and the return to idle.
  task automatic run_op(input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] ed, input logic eb, input logic eo);
    int cyc;
    logic [31:0] md;
    cyc = 0;
    @(negedge clk);
    a = va; b = vb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cyc = i;
        break;
      end
    end
    check("latency", 32'(cyc), 32'd4);
    md = va - vb;
    check("diff_table", diff, ed);
    check("diff_model", diff, md);
    check("borrow", 32'(borrow), 32'(eb));
    check("borrow_model", 32'(borrow), 32'(va < vb));
    check("overflow", 32'(overflow), 32'(eo));
    check("overflow_model", 32'(overflow),
          32'((va[31] != vb[31]) && (md[31] != va[31])));
    check("diff_no_x", 32'($isunknown(diff)), 32'd0);
    @(negedge clk);
    check("done_pulse_end", 32'(done), 32'd0);
    check("busy_end", 32'(busy), 32'd0);
    check("diff_hold", diff, ed);
  endtask

  initial begin
    int ndone;
    logic [31:0] dseen;

    vecs[0] = '{32'h5,        32'h3,        32'h2,        1'b0, 1'b0};
    vecs[1] = '{32'h0,        32'h1,        32'hffffffff, 1'b1, 1'b0};
    vecs[2] = '{32'h10000,    32'h1,        32'h0000ffff, 1'b0, 1'b0};
    vecs[3] = '{32'h3ccc0,    32'h2ccc1,    32'h0000ffff, 1'b0, 1'b0};
    vecs[4] = '{32'h80000000, 32'h1,        32'h7fffffff, 1'b0, 1'b1};
    vecs[5] = '{32'hffff,     32'hffff,     32'h0,        1'b0, 1'b0};
    vecs[6] = '{32'h7fffffff, 32'hffffffff, 32'h80000000, 1'b1, 1'b1};
    vecs[7] = '{32'h12345678, 32'h12345679, 32'hffffffff, 1'b1, 1'b0};

    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", diff, 32'd0);
    check("rst_borrow", 32'(borrow), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;

    for (int v = 0; v < 8; v++)
      run_op(vecs[v].a, vecs[v].b, vecs[v].d, vecs[v].br, vecs[v].ov);

    // Start and new operands while busy must be ignored.
    ndone = 0; dseen = '0;
    @(negedge clk);
    a = 32'h00001000; b = 32'h00000001; start = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 3) begin
        a = 32'hdeadbeef; b = 32'h00000005; start = 1'b1;
      end
      if (done === 1'b1) begin
        ndone++;
        dseen = diff;
      end
    end
    start = 1'b0;
    check("busy_ignore_diff", dseen, 32'h00000fff);
    check("busy_ignore_ndone", 32'(ndone), 32'd1);

    // Reset in the middle of CALC discards the operation.
    @(negedge clk);
    a = 32'h00000300; b = 32'h00000001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("calc_upper_zero", diff & 32'hffffff00, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_diff", diff, 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("midrst_no_done", 32'(ndone), 32'd0);
    run_op(32'h00000300, 32'h00000001, 32'h000002ff, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
